weight_tile_buffer: RTL and testbench

//  On-chip weight store that answers weight_controller address requests with a pair of
//  6x6 transformed-weight tiles (12-bit signed) per address.

---
 rtl/winocnn_pkg.sv | 20 ++
 rtl/weight_tile_buffer_packer.sv | 71 +++++++
 rtl/weight_tile_buffer.sv | 119 +++++++++++
 tb/tb_weight_tile_buffer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/winocnn_pkg.sv
// rtl/winocnn_pkg.sv - shared types and constants for the weight tile store
package winocnn_pkg;

    localparam int DATA_W = 12;
    localparam int TILE   = 6;
    localparam int ELEMS  = 2 * TILE * TILE;

    localparam logic [6:0] LAST_ELEM = 7'(ELEMS - 1);
    localparam logic [2:0] LAST_RC   = 3'(TILE - 1);

    typedef logic signed [DATA_W-1:0] elem_t;
    typedef elem_t tile_t [TILE-1:0][TILE-1:0];

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE
    } load_state_t;

endpackage

// File: rtl/weight_tile_buffer_packer.sv
// rtl/weight_tile_buffer_packer.sv - packs an element stream into a tile pair
// Fills tile 1 then tile 2 row-major; commit_o marks the handshake of the final element.
import winocnn_pkg::*;

module weight_tile_packer (
    input  logic  clk,
    input  logic  reset,
    input  logic  en,
    input  logic  wr_valid_i,
    input  elem_t wr_data_i,
    output logic  wr_ready_o,
    output logic  commit_o,
    output tile_t tile_1_o,
    output tile_t tile_2_o
);

    logic [6:0] elem_cnt;
    logic [2:0] row;
    logic [2:0] col;
    logic       half;
    logic       hs;
    tile_t      stage_1;
    tile_t      stage_2;

    assign hs         = en & wr_valid_i;
    assign wr_ready_o = en;
    assign commit_o   = hs && (elem_cnt == LAST_ELEM);

    // Dropping en (leaving LOAD) discards any partially packed entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            elem_cnt <= '0;
            row      <= '0;
            col      <= '0;
            half     <= 1'b0;
        end else if (!en || commit_o) begin
            elem_cnt <= '0;
            row      <= '0;
            col      <= '0;
            half     <= 1'b0;
        end else if (hs) begin
            elem_cnt <= elem_cnt + 7'd1;
            if (col == LAST_RC) begin
                col <= '0;
                if (row == LAST_RC) begin
                    row  <= '0;
                    half <= 1'b1;
                end else begin
                    row <= row + 3'd1;
                end
            end else begin
                col <= col + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (hs) begin
            if (!half) stage_1[row][col] <= wr_data_i;
            else       stage_2[row][col] <= wr_data_i;
        end
    end

    // The last element bypasses staging so the entry commits on its own handshake edge.
    always_comb begin
        tile_1_o                     = stage_1;
        tile_2_o                     = stage_2;
        tile_2_o[TILE-1][TILE-1]     = wr_data_i;
    end

endmodule

// File: rtl/weight_tile_buffer.sv
// rtl/weight_tile_buffer.sv - tile-pair weight store with streaming loader and 1-cycle read port
import winocnn_pkg::*;

module weight_tile_buffer #(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_start_i,
    input  logic [7:0]  load_count_i,
    input  logic        wr_valid_i,
    input  elem_t       wr_data_i,
    output logic        wr_ready_o,
    output logic        load_busy_o,
    output logic        load_done_o,
    input  logic        rd_en_i,
    input  logic [7:0]  rd_addr_i,
    output logic        rd_valid_o,
    output tile_t       rd_tile_1_o,
    output tile_t       rd_tile_2_o
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [8:0] DEPTH_W = 9'(DEPTH);

    load_state_t state, state_nxt;
    logic [7:0]  count_q;
    logic [7:0]  entry_cnt;
    logic        commit;
    logic        rd_hit;
    tile_t       p_tile_1;
    tile_t       p_tile_2;
    tile_t       mem_1 [DEPTH];
    tile_t       mem_2 [DEPTH];

    weight_tile_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .en         (state == ST_LOAD),
        .wr_valid_i (wr_valid_i),
        .wr_data_i  (wr_data_i),
        .wr_ready_o (wr_ready_o),
        .commit_o   (commit),
        .tile_1_o   (p_tile_1),
        .tile_2_o   (p_tile_2)
    );

    always_comb begin
        state_nxt   = state;
        load_busy_o = 1'b0;
        load_done_o = 1'b0;
        case (state)
            ST_IDLE: begin
                if (load_start_i)
                    state_nxt = (load_count_i == 8'd0) ? ST_DONE : ST_LOAD;
            end
            ST_LOAD: begin
                load_busy_o = 1'b1;
                if (commit && (entry_cnt + 8'd1 == count_q))
                    state_nxt = ST_DONE;
            end
            ST_DONE: begin
                load_done_o = 1'b1;
                state_nxt   = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            count_q   <= '0;
            entry_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && load_start_i) begin
                count_q   <= ({1'b0, load_count_i} > DEPTH_W) ? DEPTH_W[7:0] : load_count_i;
                entry_cnt <= '0;
            end else if (commit) begin
                entry_cnt <= entry_cnt + 8'd1;
            end
        end
    end

    // Clamped count keeps entry_cnt below DEPTH, so the low bits address the array directly.
    always_ff @(posedge clk) begin
        if (commit) begin
            mem_1[entry_cnt[AW-1:0]] <= p_tile_1;
            mem_2[entry_cnt[AW-1:0]] <= p_tile_2;
        end
    end

    assign rd_hit = ({1'b0, rd_addr_i} < DEPTH_W);

    // Nonblocking read against the same-edge commit yields the pre-write contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid_o <= 1'b0;
            for (int r = 0; r < TILE; r++) begin
                for (int c = 0; c < TILE; c++) begin
                    rd_tile_1_o[r][c] <= '0;
                    rd_tile_2_o[r][c] <= '0;
                end
            end
        end else begin
            rd_valid_o <= rd_en_i;
            if (rd_en_i) begin
                for (int r = 0; r < TILE; r++) begin
                    for (int c = 0; c < TILE; c++) begin
                        rd_tile_1_o[r][c] <= rd_hit ? mem_1[rd_addr_i[AW-1:0]][r][c] : '0;
                        rd_tile_2_o[r][c] <= rd_hit ? mem_2[rd_addr_i[AW-1:0]][r][c] : '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_weight_tile_buffer.sv
// tb/tb_weight_tile_buffer.sv - directed self-checking bench for weight_tile_buffer
module tb_weight_tile_buffer;
    import winocnn_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_start = 1'b0;
    logic [7:0]  load_count = '0;
    logic        wr_valid = 1'b0;
    elem_t       wr_data = '0;
    logic        wr_ready;
    logic        load_busy;
    logic        load_done;
    logic        rd_en = 1'b0;
    logic [7:0]  rd_addr = '0;
    logic        rd_valid;
    tile_t       rd_tile_1;
    tile_t       rd_tile_2;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int d0;

    logic [863:0] model [64];
    logic [863:0] exp_q [$];

    always #5 clk = ~clk;

    weight_tile_buffer #(.DEPTH(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .load_start_i (load_start),
        .load_count_i (load_count),
        .wr_valid_i   (wr_valid),
        .wr_data_i    (wr_data),
        .wr_ready_o   (wr_ready),
        .load_busy_o  (load_busy),
        .load_done_o  (load_done),
        .rd_en_i      (rd_en),
        .rd_addr_i    (rd_addr),
        .rd_valid_o   (rd_valid),
        .rd_tile_1_o  (rd_tile_1),
        .rd_tile_2_o  (rd_tile_2)
    );

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [863:0] pack_obs();
        logic [863:0] p;
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 6; c++) begin
                p[(r*6+c)*12 +: 12]    = rd_tile_1[r][c];
                p[(36+r*6+c)*12 +: 12] = rd_tile_2[r][c];
            end
        end
        return p;
    endfunction

    task automatic check_tiles(input string tag, input logic [863:0] e);
        logic [863:0] o;
        int bad;
        o = pack_obs();
        bad = 0;
        for (int k = 71; k >= 0; k--)
            if (o[k*12 +: 12] !== e[k*12 +: 12]) bad = k;
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s elem=%0d observed=%0d expected=%0d", tag, bad,
                   $signed(o[bad*12 +: 12]), $signed(e[bad*12 +: 12]));
        end
    endtask

    // One clock; the read request seen at the edge decides what must appear after it.
    task automatic step();
        logic exp_v;
        @(posedge clk);
        exp_v = rd_en;
        #1;
        check_bit("rd_valid", rd_valid, exp_v);
        if (exp_v) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL scoreboard observed=read expected=none");
            end else begin
                check_tiles("rd_tiles", exp_q.pop_front());
            end
        end
        if (load_done) done_cnt++;
    endtask

    task automatic set_read(input int a);
        rd_en   = 1'b1;
        rd_addr = 8'(a);
        exp_q.push_back((a < 64) ? model[a] : '0);
    endtask

    // mode 0: value=index, 1: random, 2: constant cval
    task automatic load(input int cnt, input int mode, input logic [11:0] cval, input bit gaps,
                        input int rd_entry, input int abort_after, input bit poke);
        logic [863:0] b;
        logic [11:0]  v;
        int n;
        n = 0;
        load_start = 1'b1;
        load_count = 8'(cnt);
        step();
        load_start = 1'b0;
        if (poke) begin
            load_start = 1'b1;
            load_count = 8'd0;
            step();
            load_start = 1'b0;
            check_bit("busy_after_restart", load_busy, 1'b1);
        end
        for (int e = 0; e < cnt; e++) begin
            b = '0;
            for (int k = 0; k < 72; k++) begin
                if (abort_after >= 0 && n == abort_after) begin
                    wr_valid = 1'b0;
                    return;
                end
                if (gaps && $urandom_range(0, 2) == 0) begin
                    wr_valid = 1'b0;
                    repeat ($urandom_range(1, 3)) step();
                end
                v = (mode == 0) ? 12'(k) : (mode == 1) ? 12'($urandom_range(0, 4095)) : cval;
                wr_valid = 1'b1;
                wr_data  = v;
                b[k*12 +: 12] = v;
                if (k == 71 && e == rd_entry) set_read(e);
                step();
                rd_en = 1'b0;
                n++;
            end
            model[e] = b;
        end
        wr_valid = 1'b0;
    endtask

    initial begin
        repeat (2) step();
        check_bit("rst_busy", load_busy, 1'b0);
        check_bit("rst_ready", wr_ready, 1'b0);
        check_bit("rst_done", load_done, 1'b0);
        check_tiles("rst_tiles", '0);
        reset = 1'b0;
        step();

        // 1: single entry, index pattern
        d0 = done_cnt;
        load(1, 0, 12'd0, 1'b0, -1, -1, 1'b0);
        step();
        check_int("t1_done_pulses", done_cnt - d0, 1);
        check_bit("t1_done_low", load_done, 1'b0);
        check_bit("t1_idle_ready", wr_ready, 1'b0);
        set_read(0);
        step();
        rd_en = 1'b0;
        step();

        // 6: zero-count load, then restart attempt during LOAD
        d0 = done_cnt;
        load_start = 1'b1;
        load_count = 8'd0;
        step();
        load_start = 1'b0;
        check_bit("t6_done_next", load_done, 1'b1);
        check_bit("t6_no_ready", wr_ready, 1'b0);
        step();
        check_bit("t6_done_once", load_done, 1'b0);
        check_int("t6_done_pulses", done_cnt - d0, 1);
        d0 = done_cnt;
        load(1, 1, 12'd0, 1'b0, -1, -1, 1'b1);
        step();
        check_int("t6_restart_done", done_cnt - d0, 1);
        set_read(0);
        step();
        rd_en = 1'b0;
        step();

        // 2: three entries with gaps, back-to-back reads
        load(3, 1, 12'd0, 1'b1, -1, -1, 1'b0);
        step();
        set_read(2);
        step();
        set_read(1);
        step();
        set_read(0);
        step();
        rd_en = 1'b0;
        step();

        // 3: read of entry 5 on the edge that commits it
        load(6, 2, 12'hFFF, 1'b0, -1, -1, 1'b0);
        step();
        load(6, 2, 12'd7, 1'b0, 5, -1, 1'b0);
        step();
        set_read(5);
        step();
        rd_en = 1'b0;
        step();

        // 4: out-of-range address
        set_read(200);
        step();
        rd_en = 1'b0;
        step();

        // 5: reset in the middle of entry 1
        load(2, 1, 12'd0, 1'b0, -1, 72 + 40, 1'b0);
        d0 = done_cnt;
        reset = 1'b1;
        #1;
        check_bit("t5_busy_async", load_busy, 1'b0);
        check_bit("t5_ready_async", wr_ready, 1'b0);
        repeat (2) step();
        reset = 1'b0;
        step();
        check_int("t5_no_done", done_cnt - d0, 0);
        check_bit("t5_busy", load_busy, 1'b0);
        set_read(0);
        step();
        set_read(1);
        step();
        rd_en = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
